// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT frame I/O path.
package fft_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    HANDOFF = 2'd1,
    COMPUTE = 2'd2,
    UNLOAD  = 2'd3
  } io_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int MAX_ADDR_W = 32;

  // Reverses the low 'width' bits of addr; upper bits of the result are zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] addr,
                                                   input int width);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < width) r[i] = addr[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry result FIFO behind a 1-cycle-latency memory read port.
// Handshake: a result transfers on any cycle where out_valid && out_ready;
// out_valid never drops and out_data never changes until that transfer.
module fft_out_skid
  import fft_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue,
  input  logic [DATA_W-1:0] rdata,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              pop,
  output logic              can_issue
);

  logic              inflight;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [2:0]        credit;
  logic [DATA_W-1:0] entries [SKID_DEPTH];

  assign out_valid = (count != 2'd0);
  assign out_data  = entries[rd_ptr];
  assign pop       = out_valid && out_ready;

  // A read may issue only if, after this cycle's pop, its data is guaranteed a slot.
  assign credit    = 3'(count) + 3'(inflight) - 3'(pop);
  assign can_issue = (credit < 3'(SKID_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= 1'b0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= issue;
      if (inflight) wr_ptr <= ~wr_ptr;
      if (pop)      rd_ptr <= ~rd_ptr;
      count <= count + 2'(inflight) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (inflight) entries[wr_ptr] <= rdata;
  end

endmodule

// File: rtl/fft_io_sequencer.sv
// Frame I/O controller: bit-reversed load, handoff to the FFT driver,
// natural-order unload through a small skid FIFO.
module fft_io_sequencer
  import fft_pkg::*;
#(
  parameter int N      = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_owner,
  output logic              frame_ready,
  output logic              io_busy,
  input  logic              fft_busy,
  input  logic              fft_done
);

  io_state_t         state;
  io_state_t         state_next;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W-1:0] out_cnt;
  logic [ADDR_W-1:0] wr_rev;
  logic              wr_fire;
  logic              pop;
  logic              can_issue;
  logic              last_pop;

  assign wr_fire  = in_valid && in_ready;
  assign last_pop = pop && (out_cnt == ADDR_W'(N-1));
  assign wr_rev   = ADDR_W'(bitrev(MAX_ADDR_W'(wr_cnt), ADDR_W));

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  // fft_done is only meaningful in COMPUTE; elsewhere it is ignored.
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (wr_fire && wr_cnt == ADDR_W'(N-1)) state_next = HANDOFF;
      HANDOFF: if (fft_busy) state_next = COMPUTE;
      COMPUTE: if (fft_done) state_next = UNLOAD;
      UNLOAD:  if (last_pop) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    io_busy     = 1'b1;
    mem_owner   = 1'b1;
    frame_ready = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = rd_cnt[ADDR_W-1:0];
    case (state)
      LOAD: begin
        in_ready = !reset;
        mem_addr = wr_rev;
      end
      HANDOFF: begin
        io_busy     = 1'b0;
        mem_owner   = 1'b0;
        frame_ready = 1'b1;
      end
      COMPUTE: begin
        io_busy   = 1'b0;
        mem_owner = 1'b0;
      end
      UNLOAD: mem_re = (rd_cnt < (ADDR_W+1)'(N)) && can_issue;
      default: ;
    endcase
  end

  assign mem_we    = wr_fire;
  assign mem_wdata = in_data;
  assign out_last  = out_valid && (out_cnt == ADDR_W'(N-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (wr_fire) wr_cnt <= wr_cnt + 1'b1;
      if (last_pop)    rd_cnt <= '0;
      else if (mem_re) rd_cnt <= rd_cnt + 1'b1;
      if (pop) out_cnt <= out_cnt + 1'b1;
    end
  end

  fft_out_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .issue     (mem_re),
    .rdata     (mem_rdata),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .pop       (pop),
    .can_issue (can_issue)
  );

endmodule

// File: tb/tb_fft_io_sequencer.sv
// Randomized frame-level bench for fft_io_sequencer with a queue scoreboard
// and a behavioural sample memory / FFT-driver stand-in.
module tb_fft_io_sequencer;

  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          mem_owner;
  logic          frame_ready;
  logic          io_busy;
  logic          fft_busy;
  logic          fft_done;

  fft_io_sequencer #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_owner(mem_owner), .frame_ready(frame_ready),
    .io_busy(io_busy), .fft_busy(fft_busy), .fft_done(fft_done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] samples [N];
  logic [DW-1:0] mem [N];
  int            wr_idx = 0;
  int            loads_done = 0;
  int            res_idx = 0;
  int            outstanding = 0;
  int            cyc_n = 0;
  int            first_pop_cyc = 0;
  int            last_pop_cyc = 0;
  bit            fr_chk = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  bit            fill_req = 0;
  int            out_mode = 0;
  logic          ready_pat [4];
  int            pat_i = 0;

  function automatic int tb_bitrev(input int a);
    int r = 0;
    for (int i = 0; i < AW; i++) begin
      r = (r << 1) | (a & 1);
      a = a >> 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- memory and downstream models ----------------
  always @(posedge clk) begin
    if (fill_req) begin
      for (int a = 0; a < N; a++) mem[a] <= DW'(a * 3);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= mem_re ? mem[mem_addr] : DW'($urandom);
  end

  always @(posedge clk) begin
    #1;
    case (out_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = ready_pat[pat_i]; pat_i = (pat_i + 1) % 4; end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit pop;
    cyc_n++;
    if (reset) begin
      wr_idx = 0; res_idx = 0; outstanding = 0; prev_stall = 0; fr_chk = 0;
    end else begin
      if (fr_chk) begin
        check("frame_ready_rise", frame_ready, 1);
        check("in_ready_drop", in_ready, 0);
        fr_chk = 0;
      end
      if (mem_we || mem_re) begin
        check("we_re_exclusive", mem_we && mem_re, 0);
        check("mem_owner_on_access", mem_owner, 1);
      end
      if (mem_we) begin
        check("wr_addr", mem_addr, tb_bitrev(wr_idx));
        check("wr_data", mem_wdata, in_data);
        samples[wr_idx] = in_data;
        wr_idx++;
        if (wr_idx == N) begin
          wr_idx = 0; loads_done++; fr_chk = 1;
        end
      end
      pop = out_valid && out_ready;
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_data_hold", out_data, prev_data);
      end
      if (pop) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: actual=%0h required=none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
        check("out_last", out_last, res_idx == N-1);
        if (res_idx == 0)   first_pop_cyc = cyc_n;
        if (res_idx == N-1) last_pop_cyc  = cyc_n;
        res_idx = (res_idx + 1) % N;
      end
      if (mem_re) check("outstanding_le2", (outstanding + 1 - int'(pop)) <= 2, 1);
      outstanding = outstanding + int'(mem_re) - int'(pop);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_re"}, mem_re, 0);
    check({tag, "_mem_owner"}, mem_owner, 1);
    check({tag, "_frame_ready"}, frame_ready, 0);
    check({tag, "_io_busy"}, io_busy, 1);
  endtask

  // full=1 loads until a frame completes; otherwise stops at 'target' samples.
  task automatic load_frame(input bit hold, input bit full, input int target, input int done_at);
    int start = loads_done;
    int cyc = 0;
    bit done_sent = 0;
    forever begin
      @(posedge clk); #1;
      fft_done = 1'b0;
      if (full ? (loads_done != start) : (wr_idx == target)) break;
      if (cyc > 2000) begin
        total++; bad++;
        $display("FAIL load_timeout: actual=%0d required=%0d", wr_idx, target);
        break;
      end
      if (!done_sent && wr_idx == done_at) begin
        fft_done = 1'b1; done_sent = 1;
      end
      in_valid = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data  = DW'($urandom);
      cyc++;
    end
    in_valid = 1'b0;
    if (hold && full) check("load_consecutive", cyc, N);
  endtask

  task automatic handoff_compute(input int hold_cycles, input bit simul, input bit fill3);
    repeat (hold_cycles) begin
      @(negedge clk);
      check("handoff_frame_ready", frame_ready, 1);
      check("handoff_io_busy", io_busy, 0);
      check("handoff_mem_owner", mem_owner, 0);
    end
    @(posedge clk); #1;
    fft_busy = 1'b1; fft_done = simul;
    @(posedge clk); #1;
    fft_done = 1'b0;
    if (fill3) fill_req = 1'b1;
    @(negedge clk);
    check("compute_frame_ready", frame_ready, 0);
    check("compute_mem_owner", mem_owner, 0);
    @(posedge clk); #1;
    fill_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("compute_no_read", mem_re, 0);
      check("compute_io_busy", io_busy, 0);
    end
    for (int k = 0; k < N; k++)
      exp_q.push_back(fill3 ? DW'(k * 3) : samples[tb_bitrev(k)]);
    @(posedge clk); #1;
    fft_done = 1'b1; fft_busy = 1'b0;
    @(posedge clk); #1;
    fft_done = 1'b0;
  endtask

  task automatic wait_unload(input bit streaming);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 1000);
    check("unload_back_to_load", in_ready, 1);
    check("scoreboard_drained", exp_q.size(), 0);
    if (streaming) check("unload_1_per_cycle", last_pop_cyc - first_pop_cyc, N-1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0; ready_pat[3] = 1'b1;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; fft_busy = 1'b0; fft_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);

    // Frame 1: back-to-back load, preloaded results, always-ready unload.
    out_mode = 0;
    load_frame(1, 1, N, -1);
    handoff_compute(10, 0, 1);
    wait_unload(1);

    // Frame 2: gappy load, busy+done together, 1,0,0,1 backpressure.
    out_mode = 1;
    load_frame(0, 1, N, -1);
    handoff_compute(3, 1, 0);
    wait_unload(0);

    // Frame 3: reset after 13 samples, then a full frame with a stray done in LOAD.
    load_frame(0, 0, 13, -1);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("midrst");
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("partial_no_frame_ready", frame_ready, 0);
    out_mode = 2;
    load_frame(0, 1, N, 5);
    handoff_compute(2, 0, 0);
    wait_unload(0);

    // Frame 4: another random frame with random backpressure.
    load_frame(0, 1, N, -1);
    handoff_compute(1, 0, 0);
    wait_unload(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_io_sequencer.md
Name: fft_io_sequencer

Overview:
- Frame-level I/O controller for the in-place radix-2 FFT compute driver.
- Accepts a stream of N complex samples and writes them into the sample memory at bit-reversed addresses.
- Hands the frame to the compute driver, waits for it to finish, then streams the N results out in natural order.
- Owns the sample-memory port whenever the compute driver is idle; the external memory mux selects this block when mem_owner=1.

Parameters:
N, 32, FFT length (power of two, >=4)
DATA_W, 32, packed complex sample width (re:im, DATA_W/2 each)
ADDR_W, $clog2(N), memory address width

Ports:
clk  in  1  clock
reset  in  1  sync, active-high; clock clk
in_data  in  DATA_W  input sample
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input this cycle
out_data  out  DATA_W  result sample
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_last  out  1  marks result index N-1
mem_addr  out  ADDR_W  sample memory address
mem_wdata  out  DATA_W  write data
mem_we  out  1  write enable
mem_re  out  1  read enable; mem_rdata valid exactly 1 cycle later
mem_rdata  in  DATA_W  read data
mem_owner  out  1  1 = this block drives the memory port
frame_ready  out  1  to driver input_valid
io_busy  out  1  to driver io_busy
fft_busy  in  1  from driver
fft_done  in  1  from driver, 1-cycle pulse

Behaviour:
- Reset values: state=LOAD, counters=0, in_ready=0, out_valid=0, out_last=0, mem_we=0, mem_re=0, mem_owner=1, frame_ready=0, io_busy=1, skid buffer empty. in_ready rises the first cycle after reset deasserts.
- States: LOAD, HANDOFF, COMPUTE, UNLOAD.
- LOAD:
  - in_ready=1, io_busy=1, mem_owner=1.
  - On in_valid&in_ready: mem_we=1, mem_addr=bitrev(wr_cnt), mem_wdata=in_data (combinational from the input), wr_cnt++.
  - After the write at wr_cnt=N-1: wr_cnt wraps to 0 and the state goes to HANDOFF.
- HANDOFF:
  - in_ready=0, io_busy=0, frame_ready=1, mem_owner=0.
  - On fft_busy=1 the next state is COMPUTE and frame_ready drops.
- COMPUTE:
  - io_busy=0, frame_ready=0, mem_owner=0.
  - On fft_done=1 the next state is UNLOAD.
  - fft_done seen in any other state is ignored.
- UNLOAD:
  - io_busy=1, mem_owner=1.
  - Reads issue at natural addresses 0..N-1; mem_re=1 when rd_cnt<N and (skid occupancy + reads in flight) < 2, counting a pop this cycle.
  - Read data enters the 2-entry skid FIFO; its head drives out_data/out_valid.
  - Sustains 1 result/cycle while out_ready=1.
  - out_last=1 with result index N-1.
  - After the pop of result N-1, the next state is LOAD and counters clear.
- out_valid/out_data hold stable while out_valid&!out_ready (AXI-style; no retraction).
- bitrev: reverse the ADDR_W bits, e.g. N=32: 1->16, 3->24, 6->12.
- Reset mid-frame: all state abandoned, partial frame discarded, skid flushed, outputs return to reset values next cycle.
- Simultaneous fft_done and fft_busy in HANDOFF: go to COMPUTE; the done pulse is not latched, because the driver cannot finish in the same cycle it starts.
- mem_we and mem_re are never both 1 in the same cycle; both are 0 in HANDOFF and COMPUTE.

Decomposition:
- Package fft_pkg:
  - io_state_t enum {LOAD, HANDOFF, COMPUTE, UNLOAD}
  - function bitrev(addr, width)
  - localparam SKID_DEPTH=2
- Sub-module fft_out_skid: 2-entry FIFO with push, pop, occupancy and in-flight credit tracking for the 1-cycle read latency. Holds all out_valid/out_ready logic.

Test Plan:
- Load 32 samples with in_valid held high -> 32 consecutive mem_we; addresses 0,16,8,24,4,...,31; frame_ready rises the cycle after the 32nd write.
- HANDOFF with fft_busy held low for 10 cycles -> frame_ready and io_busy=0 held steady; fft_busy=1 -> COMPUTE next cycle, frame_ready=0.
- fft_done pulse, mem preloaded with rdata=addr*3, out_ready=1 -> out_data 0,3,...,93 on 32 consecutive cycles, out_last only on 93, then in_ready=1.
- Unload with out_ready toggling 1,0,0,1 -> no lost or duplicated result, out_data stable while stalled, never more than 2 outstanding reads+entries.
- Reset asserted after 13 samples loaded -> next frame's first write goes to address 0, wr_cnt restarts, no frame_ready from the partial frame.
- fft_done pulse while in LOAD -> ignored, state stays LOAD, counters unchanged.
